// File: rtl/icache_resp.sv
// icache_resp: direct-mapped instruction cache responder, one doubleword per line, refilled over a valid/ready memory port.
// Define ICACHE_PERF_CNT_EN to build the hit/miss counters; otherwise both counter ports read zero.
module icache_resp #(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 64-3-IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req_valid_i,
  input  logic [63:0] icache_addr_i,
  input  logic        icache_data_wen_i,
  input  logic [63:0] icache_data_i,
  input  logic        icache_flush_i,
  output logic        icache_resp_valid_o,
  output logic [31:0] icache_resp_data_o,
  output logic        icache_resp_err_o,
  output logic        icache_stall_o,
  output logic        mem_req_valid_o,
  output logic [63:0] mem_req_addr_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_resp_valid_i,
  input  logic [63:0] mem_resp_data_i,
  output logic [63:0] hit_cnt_o,
  output logic [63:0] miss_cnt_o
);
  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;
  state_t state, state_n;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [63:0] lines [LINES];
  logic [63:0] miss_addr;
  logic [IDX_W-1:0] idx, miss_idx;
  logic flushed, accept, misaligned, hit, rd_hit, rd_miss, fill, unused_ok;

  assign idx        = icache_addr_i[3+IDX_W-1:3];
  assign miss_idx   = miss_addr[3+IDX_W-1:3];
  assign accept     = icache_req_valid_i && state == IDLE;
  assign misaligned = icache_addr_i[1:0] != 2'b0;
  // a same-cycle flush turns any lookup into a miss
  assign hit        = valid[idx] && tags[idx] == icache_addr_i[63:3+IDX_W] && !icache_flush_i;
  assign rd_hit     = accept && !misaligned && !icache_data_wen_i && hit;
  assign rd_miss    = accept && !misaligned && !icache_data_wen_i && !hit;
  assign fill       = state == MISS_WAIT && mem_resp_valid_i;
  assign icache_stall_o  = state != IDLE || rd_miss;
  assign mem_req_valid_o = state == MISS_REQ;
  assign mem_req_addr_o  = {miss_addr[63:3], 3'b0};
  assign unused_ok       = ^{icache_data_i, miss_addr[1:0]};

  always_comb
    state_n = state == IDLE     ? (rd_miss ? MISS_REQ : IDLE) :
              state == MISS_REQ ? (mem_req_ready_i ? MISS_WAIT : MISS_REQ) :
                                  (mem_resp_valid_i ? IDLE : MISS_WAIT);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state               <= IDLE;
      valid               <= '0;
      miss_addr           <= '0;
      flushed             <= 1'b0;
      icache_resp_valid_o <= 1'b0;
      icache_resp_err_o   <= 1'b0;
      icache_resp_data_o  <= '0;
    end else begin
      state               <= state_n;
      icache_resp_valid_o <= (accept && !rd_miss) || fill;
      icache_resp_err_o   <= accept && misaligned;
      icache_resp_data_o  <= rd_hit ? (icache_addr_i[2] ? lines[idx][63:32] : lines[idx][31:0]) :
                             fill   ? (miss_addr[2] ? mem_resp_data_i[63:32] : mem_resp_data_i[31:0]) : '0;
      if (rd_miss) miss_addr <= icache_addr_i;
      // a flush seen mid-refill keeps the incoming line from becoming valid
      flushed <= state != IDLE && state_n != IDLE && (flushed || icache_flush_i);
      if (icache_flush_i) valid <= '0;
      else begin
        if (accept && !misaligned && icache_data_wen_i) valid[idx] <= 1'b0;
        if (fill && !flushed) valid[miss_idx] <= 1'b1;
      end
    end

  always_ff @(posedge clk)
    if (fill) begin
      lines[miss_idx] <= mem_resp_data_i;
      tags[miss_idx]  <= miss_addr[63:3+IDX_W];
    end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (rd_hit) hit_cnt_o <= hit_cnt_o + 64'd1;
      if (rd_miss) miss_cnt_o <= miss_cnt_o + 64'd1;
    end
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: directed fetches with a response scoreboard and a small refill memory model.
module tb_icache_resp;
  logic clk = 1'b0, rst = 1'b1;
  logic req = 1'b0, wen = 1'b0, flush = 1'b0;
  logic [63:0] addr = '0;
  logic resp_valid, resp_err, stall, mem_req_valid;
  logic [31:0] resp_data;
  logic [63:0] mem_req_addr, hit_cnt, miss_cnt;
  logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  int vectors = 0, errors = 0, resp_cnt = 0, req_seen = 0;
  int req_wait = 0, resp_wait = 0, exp_hits = 0, exp_misses = 0;
  logic [63:0] last_req_addr = '0;
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  icache_resp dut (
    .clk(clk), .rst(rst),
    .icache_req_valid_i(req), .icache_addr_i(addr), .icache_data_wen_i(wen),
    .icache_data_i(64'hDEAD_BEEF_DEAD_BEEF), .icache_flush_i(flush),
    .icache_resp_valid_o(resp_valid), .icache_resp_data_o(resp_data),
    .icache_resp_err_o(resp_err), .icache_stall_o(stall),
    .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr),
    .mem_req_ready_i(mem_req_ready), .mem_resp_valid_i(mem_resp_valid),
    .mem_resp_data_i(mem_resp_data), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return a[63:3] == 61'h1000_0000 ? 64'h00000013_00100093 : {a[31:0] ^ 32'hFFFF_0000, a[31:0] | 32'h1};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_resp_valid"}, 64'(resp_valid), 0);
    check({tag, "_resp_data"}, 64'(resp_data), 0);
    check({tag, "_resp_err"}, 64'(resp_err), 0);
    check({tag, "_stall"}, 64'(stall), 0);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 0);
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_miss_cnt"}, miss_cnt, 0);
  endtask

  // refill memory: accepts after req_wait cycles, answers resp_wait cycles later
  initial forever begin
    @(negedge clk);
    if (mem_req_valid && !rst) begin
      req_seen++;
      last_req_addr = mem_req_addr;
      repeat (req_wait) @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      repeat (resp_wait) @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(last_req_addr);
      @(negedge clk);
      mem_resp_valid = 1'b0;
    end
  end

  always @(negedge clk)
    if (!rst && resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_resp got data=%h err=%b exp none", resp_data, resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err", 64'(resp_err), 64'(mon_e[32]));
        check("resp_data", 64'(resp_data), 64'(mon_e[31:0]));
      end
    end

  // one-cycle request pulse; counts stall cycles and optionally flushes in stall cycle fl_at
  task automatic fetch(input string nm, input logic [63:0] a, input logic w, input logic fl,
                       input int fl_at, input logic e, input logic [31:0] d, input logic miss);
    int n, cyc, reqs0;
    reqs0 = req_seen;
    exp_q.push_back({e, d});
    @(negedge clk);
    req = 1'b1; addr = a; wen = w; flush = fl;
    #1 n = int'(stall);
    @(negedge clk);
    req = 1'b0; wen = 1'b0; flush = 1'b0;
    #1 cyc = 0;
    while (stall && cyc < 100) begin
      if (n == fl_at) flush = 1'b1;
      n++;
      cyc++;
      @(negedge clk);
      flush = 1'b0;
      #1;
    end
    check({nm, "_stall_cycles"}, 64'(n), miss ? 64'(3 + req_wait + resp_wait) : 64'd0);
    check({nm, "_mem_reqs"}, 64'(req_seen - reqs0), 64'(miss));
    if (miss) check({nm, "_mem_req_addr"}, last_req_addr, {a[63:3], 3'b0});
    check({nm, "_resp_seen"}, 64'(exp_q.size()), 0);
    exp_q.delete();
    if (miss) exp_misses++;
    else if (!w && a[1:0] == 2'b0) exp_hits++;
  endtask

  task automatic check_counters(input string nm);
`ifdef ICACHE_PERF_CNT_EN
    check({nm, "_hit_cnt"}, hit_cnt, 64'(exp_hits));
    check({nm, "_miss_cnt"}, miss_cnt, 64'(exp_misses));
`else
    check({nm, "_hit_cnt"}, hit_cnt, 0);
    check({nm, "_miss_cnt"}, miss_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    resp_wait = 2;
    fetch("cold_miss", 64'h8000_0000, 0, 0, -1, 0, 32'h0010_0093, 1);
    resp_wait = 0;
    fetch("hit_hi", 64'h8000_0004, 0, 0, -1, 0, 32'h0000_0013, 0);
    fetch("conflict", 64'h8000_0200, 0, 0, -1, 0, 32'h8000_0201, 1);
    fetch("evicted", 64'h8000_0000, 0, 0, -1, 0, 32'h0010_0093, 1);
    fetch("misaligned", 64'h8000_0002, 0, 0, -1, 1, 32'h0, 0);
    resp_wait = 2;
    fetch("flush_wait", 64'h8000_0010, 0, 0, 3, 0, 32'h8000_0011, 1);
    resp_wait = 0;
    fetch("flush_refetch", 64'h8000_0010, 0, 0, -1, 0, 32'h8000_0011, 1);
    exp_q.push_back({1'b0, 32'h8000_0011});
    exp_q.push_back({1'b0, 32'h7FFF_0010});
    @(negedge clk);
    req = 1'b1; addr = 64'h8000_0010;
    #1 check("b2b_stall0", 64'(stall), 0);
    @(negedge clk);
    addr = 64'h8000_0014;
    #1 check("b2b_stall1", 64'(stall), 0);
    @(negedge clk);
    req = 1'b0;
    #1 check("b2b_resp_seen", 64'(exp_q.size()), 0);
    exp_q.delete();
    exp_hits += 2;
    fetch("write_inval", 64'h8000_0010, 1, 0, -1, 0, 32'h0, 0);
    fetch("after_write", 64'h8000_0014, 0, 0, -1, 0, 32'h7FFF_0010, 1);
    fetch("flush_on_hit", 64'h8000_0014, 0, 1, -1, 0, 32'h7FFF_0010, 1);
    fetch("hit_after_fill", 64'h8000_0010, 0, 0, -1, 0, 32'h8000_0011, 0);
    fetch("fill_idx0", 64'h8000_0000, 0, 0, -1, 0, 32'h0010_0093, 1);
    fetch("wen_flush", 64'h8000_0010, 1, 1, -1, 0, 32'h0, 0);
    fetch("after_wen_flush", 64'h8000_0004, 0, 0, -1, 0, 32'h0000_0013, 1);
    check_counters("perf");
    resp_wait = 4;
    r0 = resp_cnt;
    @(negedge clk);
    req = 1'b1; addr = 64'h8000_0400;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check_zero_outputs("mid_refill_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("late_resp_ignored", 64'(resp_cnt - r0), 0);
    exp_hits = 0;
    exp_misses = 0;
    check_counters("post_rst");
    resp_wait = 0;
    fetch("after_rst", 64'h8000_0400, 0, 0, -1, 0, 32'h8000_0401, 1);
    check_counters("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
